tick_countdown_timer: RTL and testbench

//  mm:ss BCD countdown timer. Consumes the 1-cycle clk_en pulse from the 1 Hz

---
 rtl/tick_countdown_timer.sv | 156 +++++++++++++++
 tb/tb_tick_countdown_timer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tick_countdown_timer.sv
// tick_countdown_timer
//   mm:ss BCD countdown timer. Decrements once per tick_en pulse while
//   running, stops at 00:00 and flags expiry. Loadable preset with
//   sanitising of out-of-range BCD values; start/stop control.
//
//   State table
//     IDLE    | loaded or reset, waiting for start
//     RUN     | counting down on each tick_en
//     PAUSE   | stopped mid-count, count held
//     EXPIRED | reached 00:00, only load or reset leaves
//
// Ports
//   clk      in   system clock
//   clr      in   synchronous active-low reset
//   tick_en  in   one-cycle decrement enable (1 Hz)
//   load     in   load preset (ignored while running)
//   load_min in   preset minutes, BCD
//   load_sec in   preset seconds, BCD
//   start    in   begin/resume countdown
//   stop     in   pause countdown
//   min_bcd  out  current minutes, BCD
//   sec_bcd  out  current seconds, BCD
//   running  out  high while counting
//   expired  out  high while expired
//   done     out  one-cycle pulse on entering EXPIRED
module tick_countdown_timer #(
  parameter int MAX_MIN = 99
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick_en,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       expired,
  output logic       done
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSE   = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  localparam logic [7:0] MAX_MIN_BIN = 8'(MAX_MIN);
  localparam logic [7:0] MAX_MIN_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

  logic [1:0] state_q, state_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic       running_q, expired_q, done_q, done_d;

  logic [7:0] min_load, sec_load;
  logic [7:0] min_load_bin;
  logic [7:0] min_dec, sec_dec;
  logic       count_zero;

  // Preset sanitising: malformed seconds become 59, malformed or
  // out-of-range minutes clamp to MAX_MIN.
  always_comb begin
    min_load_bin = {4'd0, load_min[7:4]} * 8'd10 + {4'd0, load_min[3:0]};

    if (load_sec[7:4] > 4'd5 || load_sec[3:0] > 4'd9) sec_load = 8'h59;
    else                                              sec_load = load_sec;

    if (load_min[7:4] > 4'd9 || load_min[3:0] > 4'd9 || min_load_bin > MAX_MIN_BIN)
      min_load = MAX_MIN_BCD;
    else
      min_load = load_min;
  end

  // One-second BCD decrement with borrow chain sec ones -> sec tens -> min.
  // Only used when the count is non-zero, so minutes never underflow.
  always_comb begin
    min_dec = min_q;
    sec_dec = sec_q;
    if (sec_q[3:0] != 4'd0) begin
      sec_dec[3:0] = sec_q[3:0] - 4'd1;
    end else if (sec_q[7:4] != 4'd0) begin
      sec_dec = {sec_q[7:4] - 4'd1, 4'd9};
    end else begin
      sec_dec = 8'h59;
      if (min_q[3:0] != 4'd0) min_dec[3:0] = min_q[3:0] - 4'd1;
      else                    min_dec      = {min_q[7:4] - 4'd1, 4'd9};
    end
  end

  assign count_zero = (min_q == 8'h00) && (sec_q == 8'h00);

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    done_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (stop) begin
          state_d = ST_PAUSE;
        end else if (tick_en) begin
          min_d = min_dec;
          sec_d = sec_dec;
          if (min_dec == 8'h00 && sec_dec == 8'h00) begin
            state_d = ST_EXPIRED;
            done_d  = 1'b1;
          end
        end
      end
      ST_IDLE, ST_PAUSE: begin
        if (load) begin
          min_d   = min_load;
          sec_d   = sec_load;
          state_d = ST_IDLE;
        end else if (start && !count_zero) begin
          // Any tick arriving with the start is intentionally dropped.
          state_d = ST_RUN;
        end
      end
      default: begin
        if (load) begin
          min_d   = min_load;
          sec_d   = sec_load;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q   <= ST_IDLE;
      min_q     <= 8'h00;
      sec_q     <= 8'h00;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      running_q <= (state_d == ST_RUN);
      expired_q <= (state_d == ST_EXPIRED);
      done_q    <= done_d;
    end
  end

  assign min_bcd = min_q;
  assign sec_bcd = sec_q;
  assign running = running_q;
  assign expired = expired_q;
  assign done    = done_q;

endmodule

// File: tb/tb_tick_countdown_timer.sv
module tb_tick_countdown_timer;

  localparam int MAX_MIN = 99;

  logic       clk = 1'b0;
  logic       clr, tick_en, load, start, stop;
  logic [7:0] load_min, load_sec;
  logic [7:0] min_bcd, sec_bcd;
  logic       running, expired, done;

  tick_countdown_timer #(.MAX_MIN(MAX_MIN)) dut (
    .clk(clk), .clr(clr), .tick_en(tick_en), .load(load),
    .load_min(load_min), .load_sec(load_sec), .start(start), .stop(stop),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .running(running),
    .expired(expired), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: count held as total seconds, state as a small enum.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_EXP} mstate_t;
  mstate_t m_st = M_IDLE;
  int      m_secs = 0;
  bit      m_done = 0;

  logic [20:0] exp_q[$];   // {min, sec, running, expired, done}
  int vectors = 0;
  int miscompares = 0;
  bit stim_done = 0;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int preset_secs(input logic [7:0] lm, input logic [7:0] ls);
    int m, s;
    if (ls[7:4] > 5 || ls[3:0] > 9) s = 59;
    else s = ls[7:4] * 10 + ls[3:0];
    if (lm[7:4] > 9 || lm[3:0] > 9 || (lm[7:4] * 10 + lm[3:0]) > MAX_MIN) m = MAX_MIN;
    else m = lm[7:4] * 10 + lm[3:0];
    return m * 60 + s;
  endfunction

  function automatic void model_step(input bit c, t, l, st, sp,
                                     input logic [7:0] lm, ls);
    m_done = 0;
    if (!c) begin
      m_secs = 0;
      m_st   = M_IDLE;
    end else begin
      case (m_st)
        M_RUN: begin
          if (sp) m_st = M_PAUSE;
          else if (t) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) begin
              m_st = M_EXP;
              m_done = 1;
            end
          end
        end
        M_IDLE, M_PAUSE: begin
          if (l) begin
            m_secs = preset_secs(lm, ls);
            m_st = M_IDLE;
          end else if (st && m_secs != 0) m_st = M_RUN;
        end
        M_EXP: begin
          if (l) begin
            m_secs = preset_secs(lm, ls);
            m_st = M_IDLE;
          end
        end
      endcase
    end
  endfunction

  task automatic step(input bit c, t, l, st, sp,
                      input logic [7:0] lm = 8'h00, input logic [7:0] ls = 8'h00);
    @(negedge clk);
    clr = c; tick_en = t; load = l; start = st; stop = sp;
    load_min = lm; load_sec = ls;
    model_step(c, t, l, st, sp, lm, ls);
    exp_q.push_back({to_bcd(m_secs / 60), to_bcd(m_secs % 60),
                     m_st == M_RUN, m_st == M_EXP, m_done});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle the registered outputs are a response; compare
  // against the oldest queued expectation.
  initial begin
    logic [20:0] want, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {min_bcd, sec_bcd, running, expired, done};
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL vec%0d: got min=%h sec=%h run=%b exp=%b done=%b, want min=%h sec=%h run=%b exp=%b done=%b",
                   vectors, got[20:13], got[12:5], got[4], got[3], got[2],
                   want[20:13], want[12:5], want[4], want[3], want[2]);
        end
      end
    end
  end

  initial begin
    clr = 0; tick_en = 0; load = 0; start = 0; stop = 0;
    load_min = 0; load_sec = 0;

    // 1: reset, then start with 00:00 is ignored
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    idle(2);

    // 2: 00:03 countdown to expiry, extra tick holds 00:00
    step(1, 0, 1, 0, 0, 8'h00, 8'h03);
    step(1, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 0, 0, 0);
      idle(9);
    end

    // 3: borrow across minutes
    step(1, 0, 1, 0, 0, 8'h01, 8'h00);
    step(1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0, 8'h10, 8'h00);
    step(1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    idle(2);

    // 4: stop+tick, start+tick both drop the tick
    step(1, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0, 8'h00, 8'h06);
    step(1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    idle(2);

    // 5: sanitising, load ignored while running
    step(1, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0, 8'hA5, 8'h7C);
    step(1, 0, 1, 0, 0, 8'h45, 8'h3A);
    step(1, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0, 8'h00, 8'h01);
    step(1, 1, 0, 0, 0);
    idle(2);

    // 6: reset mid-run, expiry then reload and restart
    step(1, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0, 8'h00, 8'h02);
    step(1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    idle(2);
    step(1, 0, 1, 0, 0, 8'h00, 8'h01);
    step(1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 1);
    step(1, 0, 1, 0, 0, 8'h00, 8'h10);
    step(1, 0, 0, 1, 0);
    step(1, 1, 1, 0, 0);
    idle(2);

    // Random phase: small presets so expiry is reached often.
    for (int i = 0; i < 3000; i++) begin
      bit c, t, l, st, sp;
      logic [7:0] lm, ls;
      c  = ($urandom_range(0, 99) != 0);
      t  = ($urandom_range(0, 2) == 0);
      l  = ($urandom_range(0, 19) == 0);
      st = ($urandom_range(0, 7) == 0);
      sp = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) begin
        lm = 8'($urandom);
        ls = 8'($urandom);
      end else begin
        lm = to_bcd($urandom_range(0, 1));
        ls = to_bcd($urandom_range(0, 20));
      end
      step(c, t, l, st, sp, lm, ls);
    end

    idle(1);
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    stim_done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
